// File: rtl/fpgann_pkg.sv
// Shared types and constants for the training-pass weight update path.
package fpgann_pkg;

   localparam int unsigned IMG_SIZE = 256;
   localparam int unsigned CLASSES  = 10;
   localparam int unsigned ADDR_W   = $clog2(IMG_SIZE);
   localparam int unsigned LABEL_W  = 4;
   localparam int unsigned DELTA_W  = 8;

   localparam logic signed [DELTA_W-1:0] ERR_MAG = 8'sd32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } seq_state_t;

   typedef logic [CLASSES-1:0][DELTA_W-1:0] delta_vec_t;

endpackage

// File: rtl/error_vector_gen.sv
// Combinational per-class error vector: +ERR_MAG at the label, -ERR_MAG at the prediction.
module error_vector_gen
   import fpgann_pkg::*;
(
   input  logic [LABEL_W-1:0] label,
   input  logic [LABEL_W-1:0] predicted,
   output delta_vec_t         err,
   output logic               invalid
);

   // Build each class entry; out-of-range indices simply never match a class.
   always_comb begin
      logic signed [DELTA_W-1:0] v;
      err = '0;
      v   = '0;
      for (int c = 0; c < CLASSES; c++) begin
         v = '0;
         if (LABEL_W'(c) == label) begin
            v = v + ERR_MAG;
         end
         if (LABEL_W'(c) == predicted) begin
            v = v - ERR_MAG;
         end
         err[c] = v;
      end
      invalid = (label >= LABEL_W'(CLASSES)) || (predicted >= LABEL_W'(CLASSES));
   end

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks every pixel address after a classification and strobes per-class weight deltas.
module weight_update_sequencer
   import fpgann_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LABEL_W-1:0]  label,
   input  logic [LABEL_W-1:0]  predicted,
   output logic                busy,
   output logic                done,
   output logic                label_err,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic                en_update,
   output delta_vec_t          weight_deltas,
   output logic [ADDR_W-1:0]   pixel_addr,
   input  logic                pixel_in
);

   localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   delta_vec_t        err_q, err_d;
   logic              label_err_q, label_err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              en_update_q, en_update_d;

   delta_vec_t        err_c;
   logic              invalid_c;

   error_vector_gen u_err_gen (
      .label     (label),
      .predicted (predicted),
      .err       (err_c),
      .invalid   (invalid_c)
   );

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         lat_q       <= '0;
         err_q       <= '0;
         label_err_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_update_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lat_q       <= lat_d;
         err_q       <= err_d;
         label_err_q <= label_err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         en_update_q <= en_update_d;
      end
   end

   // Next-state logic; registered outputs follow the next state so they line up with it.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      lat_d       = lat_q;
      err_d       = err_q;
      label_err_d = label_err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               err_d = err_c;
               if (invalid_c) begin
                  label_err_d = 1'b1;
                  state_d     = DONE;
               end else if (label == predicted) begin
                  state_d = DONE;
               end else begin
                  addr_d  = '0;
                  lat_d   = LAT_LOAD;
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (lat_q == '0) begin
               state_d = WR;
            end else begin
               lat_d = lat_q - CNT_W'(1);
            end
         end
         WR: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               lat_d   = LAT_LOAD;
               state_d = RD;
            end
         end
         DONE: begin
            label_err_d = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d == RD) || (state_d == WR);
      done_d      = (state_d == DONE);
      en_update_d = (state_d == WR);
   end

   // Deltas use the pixel presented during the write cycle itself, so they are gated live.
   assign weight_deltas = (en_update_q && pixel_in) ? err_q : '0;

   assign busy       = busy_q;
   assign done       = done_q;
   assign label_err  = label_err_q;
   assign en_update  = en_update_q;
   assign bram_addr  = addr_q;
   assign pixel_addr = addr_q;

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Directed bench for weight_update_sequencer at read latency 1 and 2.
module tb_weight_update_sequencer;
   import fpgann_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT with default read latency
   logic              start;
   logic [3:0]        label, predicted;
   logic              busy, done, label_err, en_update, pixel_in;
   logic [7:0]        bram_addr, pixel_addr;
   delta_vec_t        weight_deltas;
   bit                pix_mode;

   // DUT with read latency 2
   logic              start2;
   logic [3:0]        label2, predicted2;
   logic              busy2, done2, label_err2, en_update2, pixel_in2;
   logic [7:0]        bram_addr2, pixel_addr2;
   delta_vec_t        weight_deltas2;

   int checks = 0;
   int errors = 0;

   assign pixel_in  = pix_mode ? ~pixel_addr[0] : 1'b1;
   assign pixel_in2 = 1'b1;

   weight_update_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .label(label), .predicted(predicted),
      .busy(busy), .done(done), .label_err(label_err), .bram_addr(bram_addr),
      .en_update(en_update), .weight_deltas(weight_deltas),
      .pixel_addr(pixel_addr), .pixel_in(pixel_in)
   );

   weight_update_sequencer #(.READ_LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .label(label2), .predicted(predicted2),
      .busy(busy2), .done(done2), .label_err(label_err2), .bram_addr(bram_addr2),
      .en_update(en_update2), .weight_deltas(weight_deltas2),
      .pixel_addr(pixel_addr2), .pixel_in(pixel_in2)
   );

   function automatic delta_vec_t exp_deltas(input int lbl, input int pd, input logic pix);
      delta_vec_t v;
      v = '0;
      if (pix) begin
         v[lbl] = 8'h20;
         v[pd]  = 8'hE0;
      end
      return v;
   endfunction

   // Pulse start for one cycle; returns #1 after the sampling edge (cycle 1 of the pass).
   task automatic start_pass(input logic [3:0] lbl, input logic [3:0] pd);
      label = lbl;
      predicted = pd;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Follow a pass on dut cycle by cycle, checking every write and the closing done pulse.
   task automatic observe_pass(input int lbl, input int pd, input int exp_writes,
                               input int exp_done, input bit exp_lerr, input int inject_at);
      int n = 1;
      int writes = 0;
      int done_cycle = -1;
      delta_vec_t exp;
      while (n <= 2000) begin
         if (done) begin
            done_cycle = n;
            checks++;
            if (label_err !== exp_lerr) begin
               errors++;
               $display("FAIL label_err_at_done: got %0b expected %0b", label_err, exp_lerr);
            end
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_at_done: got %0b expected 0", busy);
            end
            break;
         end
         if (en_update) begin
            exp = exp_deltas(lbl, pd, pix_mode ? ~writes[0] : 1'b1);
            checks++;
            if (bram_addr !== 8'(writes)) begin
               errors++;
               $display("FAIL write_addr: got %0d expected %0d", bram_addr, writes);
            end
            checks++;
            if (weight_deltas !== exp) begin
               errors++;
               $display("FAIL write_deltas addr %0d: got %h expected %h", bram_addr, weight_deltas, exp);
            end
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_in_write: got %0b expected 1", busy);
            end
            writes++;
         end else begin
            checks++;
            if (weight_deltas !== '0) begin
               errors++;
               $display("FAIL idle_deltas: got %h expected 0", weight_deltas);
            end
         end
         checks++;
         if (pixel_addr !== bram_addr) begin
            errors++;
            $display("FAIL pixel_addr: got %0d expected %0d", pixel_addr, bram_addr);
         end
         start = (inject_at >= 0 && en_update && bram_addr == 8'(inject_at));
         @(posedge clk); #1;
         start = 1'b0;
         n++;
      end
      checks++;
      if (done_cycle != exp_done) begin
         errors++;
         $display("FAIL done_cycle: got %0d expected %0d", done_cycle, exp_done);
      end
      checks++;
      if (writes != exp_writes) begin
         errors++;
         $display("FAIL write_count: got %0d expected %0d", writes, exp_writes);
      end
      @(posedge clk); #1;
      checks++;
      if ({done, label_err, busy} !== 3'b000) begin
         errors++;
         $display("FAIL after_done: got done/lerr/busy %b expected 000", {done, label_err, busy});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, label_err, en_update} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, label_err, en_update});
      end
      checks++;
      if (bram_addr !== 8'd0 || weight_deltas !== '0) begin
         errors++;
         $display("FAIL reset_addr_deltas: got addr %0d deltas %h expected 0", bram_addr, weight_deltas);
      end
      checks++;
      if ({busy2, done2, en_update2} !== 3'b000 || bram_addr2 !== 8'd0) begin
         errors++;
         $display("FAIL reset_dut2: got flags %b addr %0d expected 0", {busy2, done2, en_update2}, bram_addr2);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_full_pass();
      pix_mode = 1'b0;
      start_pass(4'd3, 4'd7);
      observe_pass(3, 7, 256, 513, 1'b0, -1);
   endtask

   task automatic test_same_class();
      pix_mode = 1'b0;
      start_pass(4'd5, 4'd5);
      observe_pass(5, 5, 0, 1, 1'b0, -1);
   endtask

   task automatic test_even_pixels();
      pix_mode = 1'b1;
      start_pass(4'd0, 4'd9);
      observe_pass(0, 9, 256, 513, 1'b0, -1);
      pix_mode = 1'b0;
   endtask

   task automatic test_restart_ignored();
      pix_mode = 1'b0;
      label = 4'd3;
      predicted = 4'd7;
      start_pass(4'd3, 4'd7);
      label = 4'd1;
      predicted = 4'd2;
      observe_pass(3, 7, 256, 513, 1'b0, 40);
   endtask

   task automatic test_reset_mid_pass();
      bit hit = 1'b0;
      pix_mode = 1'b0;
      start_pass(4'd3, 4'd7);
      for (int i = 0; i < 600; i++) begin
         if (en_update && bram_addr == 8'd100) begin
            hit = 1'b1;
            rst = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reach_addr_100: got no write at 100 expected one");
      end
      checks++;
      if ({en_update, busy, done} !== 3'b000 || bram_addr !== 8'd0 || weight_deltas !== '0) begin
         errors++;
         $display("FAIL mid_pass_reset: got en/busy/done %b addr %0d expected 000 addr 0",
                  {en_update, busy, done}, bram_addr);
      end
      // rst and start together: rst wins and the start is lost
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, en_update} !== 3'b000) begin
         errors++;
         $display("FAIL rst_with_start: got busy/done/en %b expected 000", {busy, done, en_update});
      end
      start_pass(4'd3, 4'd7);
      observe_pass(3, 7, 256, 513, 1'b0, -1);
   endtask

   task automatic test_bad_label();
      start_pass(4'd12, 4'd2);
      observe_pass(12, 2, 0, 1, 1'b1, -1);
      start_pass(4'd4, 4'd10);
      observe_pass(4, 10, 0, 1, 1'b1, -1);
   endtask

   task automatic test_latency2();
      delta_vec_t exp;
      exp = exp_deltas(3, 7, 1'b1);
      label2 = 4'd3;
      predicted2 = 4'd7;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int n = 1; n <= 769; n++) begin
         if (n <= 768) begin
            checks++;
            if (en_update2 !== (n % 3 == 0) || bram_addr2 !== 8'((n - 1) / 3) || done2 !== 1'b0) begin
               errors++;
               $display("FAIL lat2_cycle %0d: got en %0b addr %0d done %0b expected en %0b addr %0d done 0",
                        n, en_update2, bram_addr2, done2, (n % 3 == 0), (n - 1) / 3);
            end
            if (en_update2) begin
               checks++;
               if (weight_deltas2 !== exp) begin
                  errors++;
                  $display("FAIL lat2_deltas: got %h expected %h", weight_deltas2, exp);
               end
            end
         end else begin
            checks++;
            if (done2 !== 1'b1 || en_update2 !== 1'b0) begin
               errors++;
               $display("FAIL lat2_done: got done %0b en %0b expected done 1 en 0", done2, en_update2);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      label = '0;
      predicted = '0;
      start2 = 1'b0;
      label2 = '0;
      predicted2 = '0;
      pix_mode = 1'b0;
      test_reset();
      test_full_pass();
      test_same_class();
      test_even_pixels();
      test_restart_ignored();
      test_reset_mid_pass();
      test_bad_label();
      test_latency2();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
